// File: rtl/keypad_entry.sv
// keypad_entry: debounced keypad entry with backspace/enter, passcode compare
// and a timed lockout after repeated failures.
// Optional build macro KEYPAD_MASK_EN: when defined, the entry output shows 4'hE
// for each occupied nibble and 0 elsewhere. The internal compare always uses
// the real digits.
module keypad_entry #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] PASSCODE    = 16'h1234,
    parameter int                  DEB_CYCLES  = 4000,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCK_CYCLES = 100000000
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [3:0]                   key_code,
    output logic                         key_valid,
    output logic [4*DIGITS-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic                         pass,
    output logic                         fail,
    output logic                         lockout
);

    localparam int ENTRY_W = 4 * DIGITS;
    localparam int LEN_W   = $clog2(DIGITS + 1);
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int FCNT_W  = $clog2(MAX_FAIL + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DIGITS);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_HELD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          sync1_q, ks_q;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                key_valid_q, key_valid_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                lockout_q, lockout_d;

    logic                stable;
    logic                accept;
    logic                is_digit, is_bksp, is_enter, mapped;
    logic [3:0]          digit_val;

    // Two-flop synchroniser; idles at "no key" so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 4'hF;
            ks_q    <= 4'hF;
        end else begin
            sync1_q <= key_code;
            ks_q    <= sync1_q;
        end
    end

    // Stability counter aligned with ks_q: it reads 0 on the cycle ks_q takes a
    // new value, so "stable" can never be inherited from the previous code.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (sync1_q != ks_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    assign stable = (deb_cnt_q == DEB_MAX);

    // Key map: digits 1-9 and B (=0), A backspace, C enter; 0/D/E/F unmapped.
    always_comb begin
        is_digit  = 1'b0;
        is_bksp   = 1'b0;
        is_enter  = 1'b0;
        digit_val = 4'h0;
        case (ks_q)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9: begin
                is_digit  = 1'b1;
                digit_val = ks_q;
            end
            4'hB:    is_digit = 1'b1;
            4'hA:    is_bksp  = 1'b1;
            4'hC:    is_enter = 1'b1;
            default: ;
        endcase
    end

    assign mapped = is_digit | is_bksp | is_enter;

    // Next-state logic: press/release FSM, lockout timer and entry datapath.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        len_d       = len_q;
        fail_cnt_d  = fail_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        key_valid_d = 1'b0;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        lockout_d   = lockout_q;
        accept      = 1'b0;

        case (state_q)
            ST_ARMED: begin
                // Unmapped codes still move to HELD so they need a release too.
                if (stable && (ks_q != 4'hF)) begin
                    state_d = ST_HELD;
                    accept  = mapped;
                end
            end
            ST_HELD: begin
                if (stable && (ks_q == 4'hF)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_LOCKED: begin
                // Exit through HELD so a key held across the lockout is not taken.
                if (lock_cnt_q == LOCK_MAX) begin
                    lock_cnt_d = '0;
                    fail_cnt_d = '0;
                    lockout_d  = 1'b0;
                    state_d    = ST_HELD;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = ST_ARMED;
        endcase

        if (accept) begin
            key_valid_d = 1'b1;
            if (is_digit) begin
                if (len_q < LEN_FULL) begin
                    entry_d = (entry_q << 4) | ENTRY_W'(digit_val);
                    len_d   = len_q + LEN_W'(1);
                end
            end else if (is_bksp) begin
                if (len_q != '0) begin
                    entry_d = entry_q >> 4;
                    len_d   = len_q - LEN_W'(1);
                end
            end else begin
                entry_d = '0;
                len_d   = '0;
                if ((len_q == LEN_FULL) && (entry_q == PASSCODE)) begin
                    pass_d     = 1'b1;
                    fail_cnt_d = '0;
                end else begin
                    fail_d = 1'b1;
                    if (fail_cnt_q == FCNT_W'(MAX_FAIL - 1)) begin
                        fail_cnt_d = FCNT_W'(MAX_FAIL);
                        lockout_d  = 1'b1;
                        lock_cnt_d = '0;
                        state_d    = ST_LOCKED;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FCNT_W'(1);
                    end
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output pulse registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt_q   <= '0;
            entry_q     <= '0;
            len_q       <= '0;
            fail_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            key_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            entry_q     <= entry_d;
            len_q       <= len_d;
            fail_cnt_q  <= fail_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            key_valid_q <= key_valid_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            lockout_q   <= lockout_d;
        end
    end

`ifdef KEYPAD_MASK_EN
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_mask
            assign entry[4*gi +: 4] = (LEN_W'(gi) < len_q) ? 4'hE : 4'h0;
        end
    endgenerate
`else
    assign entry = entry_q;
`endif

    assign key_valid = key_valid_q;
    assign entry_len = len_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign lockout   = lockout_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed plus randomized key presses checked against a
// queue-based model of the entry rules.
module tb_keypad_entry;

    localparam int          DIGITS   = 4;
    localparam logic [15:0] PASSCODE = 16'h1234;
    localparam int          DEB      = 4;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCK     = 50;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  key_code  = 4'hF;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  entry_len;
    logic        pass;
    logic        fail;
    logic        lockout;

    keypad_entry #(
        .DIGITS      (DIGITS),
        .PASSCODE    (PASSCODE),
        .DEB_CYCLES  (DEB),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .entry     (entry),
        .entry_len (entry_len),
        .pass      (pass),
        .fail      (fail),
        .lockout   (lockout)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int   obs_kv = 0, obs_pass = 0, obs_fail = 0, obs_both = 0;
    int   cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic lock_prev = 1'b0;

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (key_valid === 1'b1) obs_kv <= obs_kv + 1;
        if (pass === 1'b1) obs_pass <= obs_pass + 1;
        if (fail === 1'b1) obs_fail <= obs_fail + 1;
        if ((pass === 1'b1) && (fail === 1'b1)) obs_both <= obs_both + 1;
        if ((lockout === 1'b1) && !lock_prev) rise_cyc <= cyc;
        if ((lockout === 1'b0) && lock_prev) fall_cyc <= cyc;
        lock_prev <= (lockout === 1'b1);
    end

    // Reference model: digits as a queue, oldest first.
    logic [3:0] m_q[$];
    int         m_fcnt   = 0;
    bit         m_locked = 1'b0;

    function automatic logic [15:0] m_value();
        logic [15:0] v = 16'h0;
        foreach (m_q[i]) v = (v << 4) | {12'h0, m_q[i]};
        return v;
    endfunction

    function automatic logic [15:0] m_display();
`ifdef KEYPAD_MASK_EN
        logic [15:0] v = 16'h0;
        for (int i = 0; i < m_q.size(); i++) v[4*i +: 4] = 4'hE;
        return v;
`else
        return m_value();
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fcnt   = 0;
        m_locked = 1'b0;
    endtask

    // Apply one completed press to the model and compare against what was seen.
    task automatic apply_and_check(input logic [3:0] code, input int kv0, input int p0, input int f0);
        int ekv = 0, ep = 0, ef = 0;
        if (!m_locked) begin
            if (((code >= 4'h1) && (code <= 4'h9)) || (code == 4'hB)) begin
                ekv = 1;
                if (m_q.size() < DIGITS) m_q.push_back((code == 4'hB) ? 4'h0 : code);
            end else if (code == 4'hA) begin
                ekv = 1;
                if (m_q.size() > 0) void'(m_q.pop_back());
            end else if (code == 4'hC) begin
                ekv = 1;
                if ((m_q.size() == DIGITS) && (m_value() == PASSCODE)) begin
                    ep     = 1;
                    m_fcnt = 0;
                end else begin
                    ef = 1;
                    m_fcnt++;
                    if (m_fcnt == MAX_FAIL) begin
                        m_locked = 1'b1;
                        m_fcnt   = 0;
                    end
                end
                m_q.delete();
            end
        end
        $display("key %h: kv=%0d pass=%0d fail=%0d entry=%h len=%0d lockout=%0b", code,
                 obs_kv - kv0, obs_pass - p0, obs_fail - f0, entry, entry_len, lockout);
        check("key_valid_count", obs_kv - kv0, ekv);
        check("pass_count", obs_pass - p0, ep);
        check("fail_count", obs_fail - f0, ef);
        check("entry", entry, m_display());
        check("entry_len", entry_len, m_q.size());
        check("lockout", lockout, m_locked);
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        int kv0, p0, f0;
        kv0 = obs_kv; p0 = obs_pass; f0 = obs_fail;
        key_code = code;
        repeat (hold) @(negedge sys_clk);
        key_code = 4'hF;
        repeat (rel) @(negedge sys_clk);
        #1;
        apply_and_check(code, kv0, p0, f0);
    endtask

    task automatic rpress(input logic [3:0] code);
        press(code, $urandom_range(8, 14), $urandom_range(8, 14));
    endtask

    task automatic wait_unlock();
        int n = 0;
        while ((lockout === 1'b1) && (n < 200)) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        #1;
        check("lockout_release", lockout, 1'b0);
        check("lockout_length", fall_cyc - rise_cyc, LOCK);
        $display("lockout released after %0d cycles", fall_cyc - rise_cyc);
        m_locked = 1'b0;
    endtask

    task automatic check_all_zero();
        check("rst_entry", entry, 16'h0);
        check("rst_entry_len", entry_len, 3'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_lockout", lockout, 1'b0);
    endtask

    logic [3:0] tbl [0:19] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB,
                               4'hA, 4'hA, 4'hC, 4'hC, 4'h0, 4'hD, 4'hE, 4'h3, 4'h4, 4'h1};
    logic [3:0] seq_a [0:4] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hC};

    initial begin
        int kv0, p0, f0;

        // Reset state
        #12;
        check_all_zero();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        #1;

        // Correct passcode
        for (int i = 0; i < 5; i++) press(seq_a[i], 10, 10);

        // Bouncing key 5 yields a single event
        kv0 = obs_kv; p0 = obs_pass; f0 = obs_fail;
        for (int i = 0; i < 10; i++) begin
            key_code = (i % 2 == 0) ? 4'h5 : 4'hF;
            repeat (2) @(negedge sys_clk);
        end
        key_code = 4'h5;
        repeat (10) @(negedge sys_clk);
        key_code = 4'hF;
        repeat (10) @(negedge sys_clk);
        #1;
        apply_and_check(4'h5, kv0, p0, f0);
        check("bounce_entry", entry, 16'h0005);

        // Backspace behaviour
        press(4'hA, 10, 10);
        press(4'h1, 10, 10); press(4'h2, 10, 10); press(4'hA, 10, 10); press(4'h3, 10, 10);
        check("bksp_entry", entry, m_display());
        check("bksp_len", entry_len, 3'd2);
        for (int i = 0; i < 3; i++) press(4'hA, 10, 10);

        // Three wrong entries lock out; input ignored until release
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) press(4'h9, 10, 10);
            press(4'hC, 10, 10);
        end
        press(4'h1, 10, 10);
        wait_unlock();
        press(4'h1, 10, 10);

        // Short entry fails, overflow digits are dropped
        press(4'hA, 10, 10);
        press(4'h1, 10, 10); press(4'h2, 10, 10); press(4'h3, 10, 10); press(4'hC, 10, 10);
        for (int i = 1; i <= 5; i++) press(4'(i), 10, 10);
        press(4'hC, 10, 10);

        // Reset while a key is held mid-debounce
        press(4'h1, 10, 10); press(4'h2, 10, 10);
        key_code = 4'h5;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #2;
        check_all_zero();
        model_reset();
        key_code = 4'hF;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        kv0 = obs_kv;
        repeat (20) @(negedge sys_clk);
        #1;
        check("post_reset_no_event", obs_kv - kv0, 0);
        press(4'h7, 10, 10);

        // Randomized presses
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 5; i++) begin
                    rpress(seq_a[i]);
                    if (m_locked) wait_unlock();
                end
            end else begin
                rpress(tbl[$urandom_range(0, 19)]);
                if (m_locked) wait_unlock();
            end
        end

        check("pass_fail_exclusive", obs_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
